lc4_mc_ctrl: RTL

Multi-cycle sequencing controller for the LC4 core. Owns the instruction register, walks each instruction through fetch, decode, execute, memory and writeback, and turns the `lc4_decoder` outputs into per-cycle datapath strobes. It also handshakes with the instruction and data memory ports and stalls for long-latency ALU ops (DIV, MOD). Sits between the memories and the register-file/ALU/PC datapath.

---
 rtl/lc4_ctrl_pkg.sv | 48 ++++
 rtl/lc4_decoder.sv | 48 ++++
 rtl/lc4_mc_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lc4_ctrl_pkg.sv
// Shared types and constants for the LC4 multi-cycle controller and its decoder.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
//   state_t    : controller state, 3-bit debug encoding
//   pc_sel_t   : next-PC source select
//   OP_*       : LC4 opcodes (insn[15:12]); SUB_* : function fields of long ops
package lc4_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    typedef logic [1:0] pc_sel_t;

    localparam pc_sel_t PCSEL_PLUS1 = 2'b00;
    localparam pc_sel_t PCSEL_REL   = 2'b01;
    localparam pc_sel_t PCSEL_RS    = 2'b10;
    localparam pc_sel_t PCSEL_ABS   = 2'b11;

    localparam logic [3:0] OP_BR      = 4'b0000;
    localparam logic [3:0] OP_ARITH   = 4'b0001;
    localparam logic [3:0] OP_CMP     = 4'b0010;
    localparam logic [3:0] OP_JSR     = 4'b0100;
    localparam logic [3:0] OP_LOGIC   = 4'b0101;
    localparam logic [3:0] OP_LDR     = 4'b0110;
    localparam logic [3:0] OP_STR     = 4'b0111;
    localparam logic [3:0] OP_RTI     = 4'b1000;
    localparam logic [3:0] OP_CONST   = 4'b1001;
    localparam logic [3:0] OP_SHIFT   = 4'b1010;
    localparam logic [3:0] OP_JMP     = 4'b1100;
    localparam logic [3:0] OP_HICONST = 4'b1101;
    localparam logic [3:0] OP_TRAP    = 4'b1111;

    localparam logic [2:0] SUB_DIV = 3'b011;   // arith insn[5:3]
    localparam logic [1:0] SUB_MOD = 2'b11;    // shift/mod insn[5:4]

    // DIV and MOD are the only instructions that need the multi-cycle ALU.
    function automatic logic is_long_op(input logic [15:0] insn);
        return ((insn[15:12] == OP_ARITH) && (insn[5:3] == SUB_DIV)) ||
               ((insn[15:12] == OP_SHIFT) && (insn[5:4] == SUB_MOD));
    endfunction

endpackage

// File: rtl/lc4_decoder.sv
// LC4 instruction classifier: register/NZP write enables and memory/branch class.
// Latency: purely combinational.
// Backpressure: none.
//   i_insn_hi     : insn[15:9] (opcode, bit 11 sub-op, BR condition bits)
//   o_regfile_we  : instruction writes a register
//   o_nzp_we      : instruction updates NZP
//   o_is_load/o_is_store/o_is_branch : instruction class
module lc4_decoder
    import lc4_ctrl_pkg::*;
(
    input  logic [6:0] i_insn_hi,
    output logic       o_regfile_we,
    output logic       o_nzp_we,
    output logic       o_is_load,
    output logic       o_is_store,
    output logic       o_is_branch
);

    logic [3:0] w_op;
    assign w_op = i_insn_hi[6:3];

    always_comb begin
        o_regfile_we = 1'b0;
        o_nzp_we     = 1'b0;
        o_is_load    = 1'b0;
        o_is_store   = 1'b0;
        o_is_branch  = 1'b0;
        case (w_op)
            // BR with an empty condition mask is NOP and never redirects.
            OP_BR:      o_is_branch = (i_insn_hi[2:0] != 3'b000);
            OP_CMP:     o_nzp_we    = 1'b1;
            OP_ARITH, OP_LOGIC, OP_CONST, OP_SHIFT, OP_HICONST,
            OP_JSR, OP_TRAP: begin
                // JSR/JSRR/TRAP write the return address to R7 and set NZP.
                o_regfile_we = 1'b1;
                o_nzp_we     = 1'b1;
            end
            OP_LDR: begin
                o_regfile_we = 1'b1;
                o_nzp_we     = 1'b1;
                o_is_load    = 1'b1;
            end
            OP_STR:     o_is_store  = 1'b1;
            default: ;  // RTI, JMP/JMPR and unused opcodes write nothing
        endcase
    end

endmodule

// File: rtl/lc4_mc_ctrl.sv
// LC4 multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with datapath strobes.
// Latency: 4 cycles ALU op, 5 load/store, 3+LONG_OP_CYCLES DIV/MOD (zero-wait memories).
// Backpressure: FETCH and MEM hold their request until the matching ack; each wait cycle adds one.
//   i_imem_*/o_imem_req : instruction port     i_dmem_ack/o_dmem_* : data port
//   o_ir : instruction register                i_branch_taken : NZP test result, used in WB
//   o_alu_start/o_rf_we/o_nzp_we/o_pc_we/o_pc_sel : datapath strobes
//   o_state : debug state                      o_insn_retired : WB pulse
module lc4_mc_ctrl
    import lc4_ctrl_pkg::*;
#(
    parameter int LONG_OP_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_rdata,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    input  logic        i_dmem_ack,
    output logic [15:0] o_ir,
    input  logic        i_branch_taken,
    output logic        o_alu_start,
    output logic        o_rf_we,
    output logic        o_nzp_we,
    output logic        o_pc_we,
    output logic [1:0]  o_pc_sel,
    output logic [2:0]  o_state,
    output logic        o_insn_retired
);

    localparam logic [7:0] LONG_CNT_INIT = 8'(LONG_OP_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_ir;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_init;
    logic [4:0]  w_op5;
    logic        w_regfile_we;
    logic        w_nzp_we;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_branch;

    lc4_decoder u_decoder (
        .i_insn_hi    (r_ir[15:9]),
        .o_regfile_we (w_regfile_we),
        .o_nzp_we     (w_nzp_we),
        .o_is_load    (w_is_load),
        .o_is_store   (w_is_store),
        .o_is_branch  (w_is_branch)
    );

    assign w_op5 = r_ir[15:11];
    // EXEC exits when the counter reads zero, so the load value is dwell-1.
    assign w_cnt_init = is_long_op(r_ir) ? LONG_CNT_INIT : 8'd0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ir  <= 16'h0000;
            r_cnt <= 8'd0;
        end else begin
            if (r_state == ST_FETCH && i_imem_ack) begin
                r_ir <= i_imem_rdata;
            end
            if (r_state == ST_DECODE) begin
                r_cnt <= w_cnt_init;
            end else if (r_state == ST_EXEC && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   w_state_nxt = ST_FETCH;
            ST_FETCH:  if (i_imem_ack) w_state_nxt = ST_DECODE;
            ST_DECODE: w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = (w_is_load || w_is_store) ? ST_MEM : ST_WB;
                end
            end
            ST_MEM:    if (i_dmem_ack) w_state_nxt = ST_WB;
            ST_WB:     w_state_nxt = ST_FETCH;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_imem_req     = 1'b0;
        o_dmem_req     = 1'b0;
        o_dmem_we      = 1'b0;
        o_alu_start    = 1'b0;
        o_rf_we        = 1'b0;
        o_nzp_we       = 1'b0;
        o_pc_we        = 1'b0;
        o_pc_sel       = PCSEL_PLUS1;
        o_insn_retired = 1'b0;
        case (r_state)
            ST_FETCH: o_imem_req = 1'b1;
            // The counter only ever decrements, so it equals its load value
            // in the first EXEC cycle and never again.
            ST_EXEC:  o_alu_start = (r_cnt == w_cnt_init);
            ST_MEM: begin
                o_dmem_req = 1'b1;
                o_dmem_we  = w_is_store;
            end
            ST_WB: begin
                o_rf_we        = w_regfile_we;
                o_nzp_we       = w_nzp_we;
                o_pc_we        = 1'b1;
                o_insn_retired = 1'b1;
                if ((w_is_branch && i_branch_taken) || w_op5 == {OP_JMP, 1'b1}) begin
                    o_pc_sel = PCSEL_REL;
                end else if (w_op5 == {OP_JSR, 1'b0} || w_op5 == {OP_JMP, 1'b0} ||
                             r_ir[15:12] == OP_RTI) begin
                    o_pc_sel = PCSEL_RS;
                end else if (w_op5 == {OP_JSR, 1'b1} || r_ir[15:12] == OP_TRAP) begin
                    o_pc_sel = PCSEL_ABS;
                end
            end
            default: ;
        endcase
    end

    assign o_state = r_state;
    assign o_ir    = r_ir;

endmodule
